// File: rtl/recorder_pkg.sv
// Shared definitions for the recorder sequencer: state encodings and default sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package recorder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_PLAY   = 2'd2
    } state_t;

    // 100 MHz / 2083 gives roughly a 48 kHz sample rate.
    localparam int DEF_DIV    = 2083;
    localparam int DEF_ADDR_W = 17;

endpackage

// File: rtl/recorder_ctrl_sample_tick.sv
// Sample-rate tick generator: one-cycle o_tick every DIV cycles while enabled.
// Latency: o_tick is combinational from the counter; first tick DIV-1 cycles after counting starts.
// Backpressure: none; i_clr or a deasserted i_en zeroes the count and masks the tick.
module sample_tick #(
    parameter int DIV = 2083
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);

    localparam int             CW   = $clog2(DIV);
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    // Free-running modulo-DIV counter, held at zero while idle or being restarted.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || !i_en) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_tick = i_en && !i_clr && (r_cnt == LAST);

endmodule

// File: rtl/recorder_ctrl.sv
// Recorder sequencer: button events drive IDLE/RECORD/PLAY and sample-memory strobes.
// Latency: state follows an event by one cycle; strobes land DIV cycles after state entry.
// Backpressure: none; events are single-cycle pulses, priority stop > rec_dn > play_dn.
module recorder_ctrl
    import recorder_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DIV    = DEF_DIV
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_rec_dn,
    input  logic              i_rec_up,
    input  logic              i_play_dn,
    input  logic              i_stop_dn,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic              o_mem_re,
    output logic [1:0]        o_state,
    output logic [ADDR_W:0]   o_rec_len,
    output logic              o_done
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_rec_len;
    logic              r_we;
    logic              r_re;
    logic              r_done;

    logic w_tick;
    logic w_en;
    logic w_clr;
    logic w_last_play;

    // Tick counter runs only while recording or playing; a restart from PLAY
    // (preempting record or replay) must re-align it to the new entry cycle.
    assign w_en  = (r_state == ST_RECORD) || (r_state == ST_PLAY);
    assign w_clr = (r_state == ST_PLAY) && !i_stop_dn && (i_rec_dn || i_play_dn);

    // Final playback read is the one at address rec_len-1.
    assign w_last_play = ({1'b0, r_addr} == (r_rec_len - (ADDR_W+1)'(1)));

    sample_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_clr),
        .i_en    (w_en),
        .o_tick  (w_tick)
    );

    // Sequencer FSM with registered strobes, address counter and recorded length.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_rec_len <= '0;
            r_we      <= 1'b0;
            r_re      <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_re   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_stop_dn) begin
                        r_state <= ST_IDLE;
                    end else if (i_rec_dn) begin
                        r_state   <= ST_RECORD;
                        r_addr    <= '0;
                        r_rec_len <= '0;
                    end else if (i_play_dn && (r_rec_len != '0)) begin
                        r_state <= ST_PLAY;
                        r_addr  <= '0;
                    end
                end
                ST_RECORD: begin
                    // A write already on the bus always counts, even if we leave now.
                    if (r_we) begin
                        r_rec_len <= r_rec_len + (ADDR_W+1)'(1);
                    end
                    if (i_stop_dn || i_rec_up || (r_we && (r_addr == ADDR_MAX))) begin
                        r_state <= ST_IDLE;
                        r_addr  <= '0;
                        r_done  <= 1'b1;
                    end else begin
                        if (r_we) begin
                            r_addr <= r_addr + ADDR_W'(1);
                        end
                        r_we <= w_tick;
                    end
                end
                ST_PLAY: begin
                    if (i_stop_dn) begin
                        r_state <= ST_IDLE;
                        r_addr  <= '0;
                        r_done  <= 1'b1;
                    end else if (i_rec_dn) begin
                        r_state   <= ST_RECORD;
                        r_addr    <= '0;
                        r_rec_len <= '0;
                        r_done    <= 1'b1;
                    end else if (i_play_dn) begin
                        r_addr <= '0;
                    end else if (r_re && w_last_play) begin
                        r_state <= ST_IDLE;
                        r_addr  <= '0;
                        r_done  <= 1'b1;
                    end else begin
                        if (r_re) begin
                            r_addr <= r_addr + ADDR_W'(1);
                        end
                        r_re <= w_tick;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_addr  <= '0;
                end
            endcase
        end
    end

    assign o_mem_addr = r_addr;
    assign o_mem_we   = r_we;
    assign o_mem_re   = r_re;
    assign o_state    = r_state;
    assign o_rec_len  = r_rec_len;
    assign o_done     = r_done;

endmodule
